acc_job_scheduler: RTL and testbench

//  Sequences the KNN and SVM classification engines: accepts one job (mode, k, threshold) per handshake,

---
 rtl/acc_job_scheduler_if.sv | 54 +++++
 rtl/acc_job_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_acc_job_scheduler.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/acc_job_scheduler_if.sv
// -----------------------------------------------------------------------------
// acc_job_scheduler_if
// Purpose : Groups every handshake and engine-control signal of the job
//           scheduler into one bundle. The host, the KNN core and the SVM core
//           sit on the master side. The scheduler sits on the slave side.
// Signals :
//   req_valid/req_ready/req_mode/req_k/req_thr   job request handshake
//   knn_control/knn_start/knn_rstn               KNN core configuration/control
//   knn_done/knn_class                           KNN core status
//   svm_start/svm_rstn                           SVM core control
//   svm_done/svm_class                           SVM core status
//   res_valid/res_ready/res_class/res_mode/res_timeout   result handshake
//   busy                                         scheduler not idle
// -----------------------------------------------------------------------------
interface acc_job_scheduler_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_mode;
    logic [1:0]  req_k;
    logic [10:0] req_thr;
    logic [31:0] knn_control;
    logic        knn_start;
    logic        knn_rstn;
    logic        knn_done;
    logic        knn_class;
    logic        svm_start;
    logic        svm_rstn;
    logic        svm_done;
    logic        svm_class;
    logic        res_valid;
    logic        res_ready;
    logic        res_class;
    logic [1:0]  res_mode;
    logic        res_timeout;
    logic        busy;

    // Host and engines: drive requests/status, observe controls/results
    modport master (
        output req_valid, req_mode, req_k, req_thr,
        output knn_done, knn_class, svm_done, svm_class, res_ready,
        input  req_ready, knn_control, knn_start, knn_rstn,
        input  svm_start, svm_rstn, res_valid, res_class, res_mode,
        input  res_timeout, busy
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_mode, req_k, req_thr,
        input  knn_done, knn_class, svm_done, svm_class, res_ready,
        output req_ready, knn_control, knn_start, knn_rstn,
        output svm_start, svm_rstn, res_valid, res_class, res_mode,
        output res_timeout, busy
    );
endinterface

// File: rtl/acc_job_scheduler.sv
// -----------------------------------------------------------------------------
// acc_job_scheduler
// Purpose : Sequences the KNN and SVM classification engines. The scheduler
//           accepts one job (mode, k, threshold) per handshake. It starts the
//           selected engine(s) and waits for every selected done or for a
//           timeout. It then pulses the engine reset(s) to return the cores to
//           Idle and reports one combined decision.
// Ports   :
//   CLK     in  clock
//   RESETn  in  synchronous active-low reset
//   bus     acc_job_scheduler_if.slave (request, engine control, result)
// Engine index 0 = KNN (mode bit 0), index 1 = SVM (mode bit 1).
// -----------------------------------------------------------------------------
module acc_job_scheduler #(
    parameter int TIMEOUT_CYC = 4096,   // WAIT cycles before abort (>=2)
    parameter int TO_W        = 13,     // counter width, holds TIMEOUT_CYC
    parameter int CLR_CYC     = 2,      // engine reset pulse length (>=1)
    parameter bit COMBINE     = 1'b0    // mode 11: 0 = knn|svm, 1 = knn&svm
) (
    input  logic               CLK,
    input  logic               RESETn,
    acc_job_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CLEAR  = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] CLR_LAST = TO_W'(CLR_CYC - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [TO_W-1:0] r_cnt;         // WAIT timeout counter, reused to time CLEAR
    logic [TO_W-1:0] w_cnt_next;
    logic            r_timeout;
    logic            w_timeout_next;
    logic            r_rst_ok;      // low while RESETn held and for the cycle it is sampled high
    logic [1:0]      r_mode;
    logic [1:0]      r_k;
    logic [10:0]     r_thr;
    logic [1:0]      r_got;         // sticky per-engine done seen in this job
    logic [1:0]      r_cls;         // class latched on the first done
    logic            r_res_class;
    logic [1:0]      r_res_mode;
    logic            r_res_timeout;

    logic [1:0]      w_done;
    logic [1:0]      w_cls_in;
    logic [1:0]      w_first_done;
    logic [1:0]      w_got_now;
    logic [1:0]      w_got_next;
    logic [1:0]      w_cls_next;
    logic [1:0]      w_start;
    logic [1:0]      w_eng_rstn;
    logic            w_all_done;
    logic            w_accept;
    logic            w_enter_report;
    logic            w_res_class_next;

    assign w_done   = {bus.svm_done,  bus.knn_done};
    assign w_cls_in = {bus.svm_class, bus.knn_class};

    // Per-engine tracking and control. An unselected engine is never started
    // or reset, and its done line is ignored.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_engine
            assign w_first_done[gi] = (r_state == ST_WAIT) && r_mode[gi]
                                      && w_done[gi] && !r_got[gi];
            assign w_got_now[gi]    = r_got[gi] | w_first_done[gi];
            assign w_got_next[gi]   = (r_state == ST_LAUNCH) ? 1'b0 : w_got_now[gi];
            assign w_cls_next[gi]   = w_first_done[gi] ? w_cls_in[gi] : r_cls[gi];
            assign w_start[gi]      = (r_state == ST_LAUNCH) && r_mode[gi];
            assign w_eng_rstn[gi]   = r_rst_ok && !((r_state == ST_CLEAR) && r_mode[gi]);
        end
    endgenerate

    // A done arriving in the same cycle as the timeout still completes the job.
    assign w_all_done = &(w_got_now | ~r_mode);

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_timeout_next = r_timeout;
        w_accept       = 1'b0;
        w_enter_report = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_accept       = 1'b1;
                    w_timeout_next = 1'b0;
                    if (bus.req_mode == 2'b00) begin
                        w_state_next   = ST_REPORT;
                        w_enter_report = 1'b1;
                    end else begin
                        w_state_next = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                w_cnt_next   = '0;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_all_done) begin
                    w_cnt_next     = '0;
                    w_timeout_next = 1'b0;
                    w_state_next   = ST_CLEAR;
                end else if (r_cnt == TO_LAST) begin
                    w_cnt_next     = '0;
                    w_timeout_next = 1'b1;
                    w_state_next   = ST_CLEAR;
                end else begin
                    w_cnt_next = r_cnt + TO_W'(1);
                end
            end
            ST_CLEAR: begin
                if (r_cnt == CLR_LAST) begin
                    w_state_next   = ST_REPORT;
                    w_enter_report = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + TO_W'(1);
                end
            end
            ST_REPORT: begin
                if (bus.res_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Decision captured on entry into REPORT. A timed-out job always reports 0.
    always_comb begin
        w_res_class_next = 1'b0;
        if (!w_accept && !r_timeout) begin
            case (r_mode)
                2'b01:   w_res_class_next = r_cls[0];
                2'b10:   w_res_class_next = r_cls[1];
                2'b11:   w_res_class_next = COMBINE ? (r_cls[0] & r_cls[1])
                                                    : (r_cls[0] | r_cls[1]);
                default: w_res_class_next = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_timeout     <= 1'b0;
            r_rst_ok      <= 1'b0;
            r_mode        <= 2'b00;
            r_k           <= 2'b00;
            r_thr         <= 11'd0;
            r_got         <= 2'b00;
            r_cls         <= 2'b00;
            r_res_class   <= 1'b0;
            r_res_mode    <= 2'b00;
            r_res_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_timeout <= w_timeout_next;
            r_rst_ok  <= 1'b1;
            r_got     <= w_got_next;
            r_cls     <= w_cls_next;
            if (w_accept) begin
                r_mode <= bus.req_mode;
                r_k    <= bus.req_k;
                r_thr  <= bus.req_thr;
            end
            if (w_enter_report) begin
                r_res_class   <= w_res_class_next;
                r_res_mode    <= w_accept ? bus.req_mode : r_mode;
                r_res_timeout <= w_accept ? 1'b0 : r_timeout;
            end
        end
    end

    assign bus.req_ready   = (r_state == ST_IDLE);
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.knn_control = {19'd0, r_thr, r_k};
    assign bus.knn_start   = w_start[0];
    assign bus.svm_start   = w_start[1];
    assign bus.knn_rstn    = w_eng_rstn[0];
    assign bus.svm_rstn    = w_eng_rstn[1];
    assign bus.res_valid   = (r_state == ST_REPORT);
    assign bus.res_class   = r_res_class;
    assign bus.res_mode    = r_res_mode;
    assign bus.res_timeout = r_res_timeout;

endmodule

// File: tb/tb_acc_job_scheduler.sv
// -----------------------------------------------------------------------------
// tb_acc_job_scheduler
// Drives jobs into acc_job_scheduler and emulates the KNN/SVM engines.
// Each job result, latency and reset pulse is compared against a reference
// model. The model works from the job-level rules: selected engines, done
// times, timeout limit and decision combine.
// -----------------------------------------------------------------------------
module tb_acc_job_scheduler;
    localparam int TIMEOUT_CYC = 4096;
    localparam int CLR_CYC     = 2;
    localparam bit COMBINE     = 1'b0;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   job_no = 0;

    acc_job_scheduler_if dif ();

    acc_job_scheduler #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (13),
        .CLR_CYC     (CLR_CYC),
        .COMBINE     (COMBINE)
    ) dut (
        .CLK    (clk),
        .RESETn (rstn),
        .bus    (dif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s job=%0d observed=%0h expected=%0h", tag, job_no, obs, exp);
        end
    endtask

    // Reference model: which WAIT cycle ends the job, whether it times out,
    // and the decision that must be reported.
    task automatic model(input logic [1:0] mode, input int kidx, input int sidx,
                         input logic kc, input logic sc,
                         output int fin, output logic to, output logic cls);
        bit ok_k, ok_s;
        int last;
        ok_k = !mode[0] || (kidx >= 0 && kidx <= TIMEOUT_CYC - 1);
        ok_s = !mode[1] || (sidx >= 0 && sidx <= TIMEOUT_CYC - 1);
        to   = !(ok_k && ok_s);
        last = 0;
        if (mode[0] && kidx > last) last = kidx;
        if (mode[1] && sidx > last) last = sidx;
        fin = to ? TIMEOUT_CYC - 1 : last;
        if (to)              cls = 1'b0;
        else if (mode == 1)  cls = kc;
        else if (mode == 2)  cls = sc;
        else if (mode == 3)  cls = COMBINE ? (kc & sc) : (kc | sc);
        else                 cls = 1'b0;
    endtask

    // One complete job. kidx/sidx: WAIT-cycle index where the engine raises
    // done (-1 = never). rdly: cycles res_ready is held low in REPORT.
    // Called at a negedge with the scheduler in IDLE and returns at a negedge in IDLE.
    task automatic run_job(input logic [1:0] mode, input logic [1:0] k, input logic [10:0] thr,
                           input int kidx, input int sidx, input logic kc, input logic sc,
                           input int rdly);
        int   fin, rep_c, klow, slow, extra_start, bad_ready;
        logic to, cls;
        bit   krst, srst;
        logic [31:0] ctl;
        job_no++;
        model(mode, kidx, sidx, kc, sc, fin, to, cls);
        ctl = {19'd0, thr, k};
        chk("idle_req_ready", 32'(dif.req_ready), 32'd1);
        dif.req_valid = 1'b1;
        dif.req_mode  = mode;
        dif.req_k     = k;
        dif.req_thr   = thr;
        @(negedge clk);
        dif.req_valid = 1'b0;
        dif.req_mode  = 2'($urandom);
        if (mode == 2'b00) begin
            chk("m00_start", {30'd0, dif.svm_start, dif.knn_start}, 32'd0);
        end else begin
            chk("launch_start", {30'd0, dif.svm_start, dif.knn_start}, 32'(mode));
            chk("launch_ctl", dif.knn_control, ctl);
            rep_c = -1; klow = 0; slow = 0; extra_start = 0; bad_ready = 0;
            krst = 0; srst = 0;
            dif.knn_done = 1'b0;
            dif.svm_done = 1'b0;
            for (int c = 0; c < TIMEOUT_CYC + CLR_CYC + 20; c++) begin
                @(negedge clk);
                if (dif.res_valid) begin
                    rep_c = c;
                    break;
                end
                if (!dif.knn_rstn) begin klow++; krst = 1; end
                if (!dif.svm_rstn) begin slow++; srst = 1; end
                if (dif.knn_start || dif.svm_start) extra_start++;
                if (dif.req_ready) bad_ready++;
                // Engine emulation: done is sticky until the engine is reset;
                // class is only meaningful while done is high.
                dif.knn_done  = (kidx >= 0 && c >= kidx && !krst);
                dif.svm_done  = (sidx >= 0 && c >= sidx && !srst);
                dif.knn_class = dif.knn_done ? kc : 1'($urandom);
                dif.svm_class = dif.svm_done ? sc : 1'($urandom);
            end
            chk("report_latency", 32'(rep_c), 32'(fin + 1 + CLR_CYC));
            chk("knn_rstn_low", 32'(klow), mode[0] ? 32'(CLR_CYC) : 32'd0);
            chk("svm_rstn_low", 32'(slow), mode[1] ? 32'(CLR_CYC) : 32'd0);
            chk("extra_start", 32'(extra_start), 32'd0);
            chk("busy_req_ready", 32'(bad_ready), 32'd0);
            dif.knn_done = 1'b0;
            dif.svm_done = 1'b0;
        end
        // REPORT: outputs must stay put while res_ready is low, even with a
        // competing request pending.
        for (int i = 0; i <= rdly; i++) begin
            chk("res_valid", 32'(dif.res_valid), 32'd1);
            chk("res_class", 32'(dif.res_class), 32'(cls));
            chk("res_mode", 32'(dif.res_mode), 32'(mode));
            chk("res_timeout", 32'(dif.res_timeout), 32'(to));
            chk("report_ready", {30'd0, dif.req_ready, dif.busy}, 32'd1);
            chk("report_ctl", dif.knn_control, ctl);
            dif.req_valid = (i < rdly);
            dif.req_thr   = 11'($urandom);
            if (i < rdly) @(negedge clk);
        end
        dif.req_valid = 1'b0;
        dif.res_ready = 1'b1;
        @(negedge clk);
        dif.res_ready = 1'b0;
        chk("post_hs", {29'd0, dif.res_valid, dif.req_ready, dif.busy}, 32'b010);
    endtask

    initial begin
        int km, sm, kd, sd;
        dif.req_valid = 1'b0;
        dif.req_mode  = 2'b00;
        dif.req_k     = 2'b00;
        dif.req_thr   = 11'd0;
        dif.knn_done  = 1'b0;
        dif.knn_class = 1'b0;
        dif.svm_done  = 1'b0;
        dif.svm_class = 1'b0;
        dif.res_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready_busy", {30'd0, dif.req_ready, dif.busy}, 32'b10);
        chk("rst_rstn", {30'd0, dif.svm_rstn, dif.knn_rstn}, 32'd0);
        chk("rst_res", {27'd0, dif.res_valid, dif.res_class, dif.res_mode, dif.res_timeout}, 32'd0);
        chk("rst_ctl", dif.knn_control, 32'd0);
        chk("rst_start", {30'd0, dif.svm_start, dif.knn_start}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rel_rstn", {30'd0, dif.svm_rstn, dif.knn_rstn}, 32'b11);

        // KNN only, done 5 cycles after start (WAIT index 4)
        run_job(2'b01, 2'd2, 11'd300, 4, -1, 1'b1, 1'b0, 0);
        chk("ctl_04b2", dif.knn_control, 32'h0000_04B2);
        // Both engines: SVM early class 0, KNN late class 1
        run_job(2'b11, 2'd1, 11'd17, 39, 2, 1'b1, 1'b0, 1);
        // SVM never finishes -> timeout
        run_job(2'b10, 2'd0, 11'd5, -1, -1, 1'b0, 1'b1, 0);
        // KNN done exactly on the last WAIT cycle wins over the timeout
        run_job(2'b01, 2'd3, 11'd2047, TIMEOUT_CYC - 1, -1, 1'b1, 1'b0, 10);
        // Mode 00, back to back
        for (int i = 0; i < 3; i++)
            run_job(2'b00, 2'($urandom), 11'($urandom), -1, -1, 1'b1, 1'b1, i);
        // Unselected engine finishing is ignored
        run_job(2'b10, 2'd1, 11'd9, 1, 6, 1'b1, 1'b0, 0);

        // Randomized jobs
        for (int j = 0; j < 30; j++) begin
            km = $urandom_range(0, 3);
            kd = $urandom_range(1, 60);
            sd = $urandom_range(1, 60);
            if ($urandom_range(0, 15) == 0) kd = -1;
            if ($urandom_range(0, 15) == 0) sd = -1;
            sm = $urandom_range(0, 3);
            run_job(2'(km), 2'($urandom), 11'($urandom), kd, sd,
                    1'($urandom), 1'($urandom), sm);
        end

        // Reset in the middle of WAIT
        job_no++;
        dif.req_valid = 1'b1;
        dif.req_mode  = 2'b11;
        @(negedge clk);
        dif.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midjob_busy", 32'(dif.busy), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        chk("midrst_state", {29'd0, dif.res_valid, dif.req_ready, dif.busy}, 32'b010);
        chk("midrst_rstn", {30'd0, dif.svm_rstn, dif.knn_rstn}, 32'd0);
        @(negedge clk);
        chk("midrst_rstn2", {30'd0, dif.svm_rstn, dif.knn_rstn}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("midrel_rstn", {30'd0, dif.svm_rstn, dif.knn_rstn}, 32'b11);
        chk("midrel_res", 32'(dif.res_valid), 32'd0);
        run_job(2'b11, 2'd2, 11'd100, 3, 7, 1'b0, 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
